// File: rtl/key_debounce_irq_ctrl.sv
// Push-button controller: per-key synchroniser and debouncer, edge detection,
// write-1-to-clear edge capture and a maskable level interrupt on an Avalon-MM slave.
module key_debounce_irq_ctrl #(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic [1:0]        address,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic              read,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] stable, stable_d;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] fall, rise, ev;
  logic [WIDTH-1:0] mask, mask_next;
  logic [WIDTH-1:0] edgecap, edgecap_next, clr;
  logic [31:0]      rd_next;
  logic             wr_en;
  logic             unused_bus;

  assign wr_en      = chipselect & write;
  // Reads are side-effect free and upper write bits are don't-care.
  assign unused_bus = &{1'b0, read, writedata};

  // Keys idle high, so every stage resets to ones to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '1;
      sync2    <= '1;
      stable   <= '1;
      stable_d <= '1;
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1    <= in_port;
      sync2    <= sync1;
      stable_d <= stable;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    fall = stable_d & ~stable;
    rise = ~stable_d & stable;
    case (EDGE_TYPE)
      0:       ev = fall;
      1:       ev = rise;
      default: ev = fall | rise;
    endcase
  end

  // A new event and a W1C on the same bit resolve in favour of the event.
  always_comb begin
    clr          = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
    mask_next    = (wr_en && address == 2'd1) ? writedata[WIDTH-1:0] : mask;
    edgecap_next = (edgecap & ~clr) | ev;
  end

  always_comb begin
    rd_next = '0;
    case (address)
      2'd0: rd_next[WIDTH-1:0] = stable;
      2'd1: rd_next[WIDTH-1:0] = mask;
      2'd2: rd_next[WIDTH-1:0] = edgecap;
      2'd3: rd_next[WIDTH-1:0] = sync2;
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask     <= '0;
      edgecap  <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      mask     <= mask_next;
      edgecap  <= edgecap_next;
      irq      <= |(edgecap_next & mask_next);
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_key_debounce_irq_ctrl.sv
// Scoreboard bench: a history-based reference model predicts readdata and irq
// every cycle; a monitor pops and compares on the falling edge.
module tb_key_debounce_irq_ctrl;

  localparam int unsigned W = 2;
  localparam int unsigned D = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          chipselect;
  logic [1:0]    address;
  logic          write;
  logic [31:0]   writedata;
  logic          read;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata;
  logic          irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_rd_q [$];
  logic        exp_irq_q[$];

  key_debounce_irq_ctrl #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(16),
    .EDGE_TYPE(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .chipselect(chipselect),
    .address(address),
    .write(write),
    .writedata(writedata),
    .read(read),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: a key's debounced value becomes v once the synchronised
  // input has shown v on each of the last D sampled cycles.
  logic [W-1:0] m_p1, m_p2, m_stb, m_stb_d, m_msk, m_ecap;
  logic [W-1:0] m_hist[$];

  always @(posedge clk) begin : model
    logic [31:0]  rd;
    logic [W-1:0] ev, clr, nstb, nmsk, necap;
    logic         ir, same, v;
    if (reset) begin
      m_p1 = '1; m_p2 = '1; m_stb = '1; m_stb_d = '1;
      m_msk = '0; m_ecap = '0;
      m_hist.delete();
      rd = '0;
      ir = 1'b0;
    end else begin
      rd = '0;
      case (address)
        2'd0: rd[W-1:0] = m_stb;
        2'd1: rd[W-1:0] = m_msk;
        2'd2: rd[W-1:0] = m_ecap;
        default: rd[W-1:0] = m_p2;
      endcase
      m_hist.push_back(m_p2);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      nstb = m_stb;
      if (m_hist.size() == D) begin
        for (int b = 0; b < W; b++) begin
          v = m_hist[0][b];
          same = 1'b1;
          for (int k = 1; k < D; k++) if (m_hist[k][b] != v) same = 1'b0;
          if (same && v != m_stb[b]) nstb[b] = v;
        end
      end
      ev    = m_stb_d & ~m_stb;
      clr   = (chipselect && write && address == 2'd2) ? writedata[W-1:0] : '0;
      nmsk  = (chipselect && write && address == 2'd1) ? writedata[W-1:0] : m_msk;
      necap = (m_ecap & ~clr) | ev;
      ir    = |(necap & nmsk);
      m_p2 = m_p1; m_p1 = in_port;
      m_stb_d = m_stb; m_stb = nstb;
      m_msk = nmsk; m_ecap = necap;
    end
    exp_rd_q.push_back(rd);
    exp_irq_q.push_back(ir);
  end

  logic [31:0] e_rd;
  logic        e_irq;

  always @(negedge clk) begin
    if (exp_rd_q.size() > 0) begin
      e_rd = exp_rd_q.pop_front();
      n_checks++;
      if (readdata !== e_rd) begin
        n_fail++;
        $display("FAIL readdata @%0t addr=%0d: got %h expected %h", $time, address, readdata, e_rd);
      end
    end
    if (exp_irq_q.size() > 0) begin
      e_irq = exp_irq_q.pop_front();
      n_checks++;
      if (irq !== e_irq) begin
        n_fail++;
        $display("FAIL irq @%0t: got %b expected %b", $time, irq, e_irq);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = 2'd0; writedata = '0; in_port = '1;
    cycles(3);
    reset = 1'b0;
    chipselect = 1'b1; read = 1'b1;

    // Reset state reads
    address = 2'd0; cycles(2);
    address = 2'd2; cycles(2);

    // Key0 press with mask clear
    in_port[0] = 1'b0; address = 2'd0; cycles(8);
    address = 2'd2; cycles(2);

    // Masked interrupt on a fresh press, then W1C
    in_port[0] = 1'b1; cycles(8);
    bus_write(2'd1, 32'h1);
    bus_write(2'd2, 32'h1);
    in_port[0] = 1'b0; address = 2'd2; cycles(9);
    bus_write(2'd2, 32'h1);
    address = 2'd2; cycles(3);

    // Short glitch on key1
    in_port[1] = 1'b0; address = 2'd0; cycles(3);
    in_port[1] = 1'b1; cycles(8);
    address = 2'd2; cycles(2);

    // W1C on key1 in the same cycle as its fall event
    bus_write(2'd1, 32'h3);
    in_port[1] = 1'b0; cycles(6);
    bus_write(2'd2, 32'h2);
    address = 2'd2; cycles(3);

    // Reset while key0 is mid-debounce
    in_port = '1; cycles(10);
    bus_write(2'd2, 32'h3);
    in_port[0] = 1'b0; address = 2'd0; cycles(4);
    reset = 1'b1; cycles(1);
    reset = 1'b0; cycles(10);
    address = 2'd2; cycles(2);
    address = 2'd1; cycles(2);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) in_port[b] = ~in_port[b];
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 7) != 0);
      read       = 1'($urandom_range(0, 1));
      write      = ($urandom_range(0, 9) == 0);
      writedata  = $urandom;
      reset      = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    reset = 1'b0; write = 1'b0; chipselect = 1'b0; read = 1'b0;
    cycles(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
